stoch_vec_decoder: RTL and testbench

STOCH_VEC_DECODER -- requirements
Module: stoch_vec_decoder

---
 rtl/stoch_vec_decoder.sv | 121 ++++++++++++
 tb/tb_stoch_vec_decoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/stoch_vec_decoder.sv
// Parallel decoder for signed stochastic bitstreams.
// Each lane adds (in_p - in_n) over a window of 2^WIN_LOG2 samples. The final sum is held on
// out_value until the consumer accepts it. The result is the lane mean with WIN_LOG2 fractional
// bits.
module stoch_vec_decoder #(
  parameter int unsigned VEC_LEN  = 2,
  parameter int unsigned WIN_LOG2 = 8,
  localparam int unsigned OUT_WIDTH = WIN_LOG2 + 2
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           start,
  input  logic [VEC_LEN-1:0]             in_p,
  input  logic [VEC_LEN-1:0]             in_n,
  output logic                           busy,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [VEC_LEN*OUT_WIDTH-1:0]   out_value,
  output logic                           start_err
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  localparam int unsigned FlatW = VEC_LEN * OUT_WIDTH;

  state_e               state_q, state_d;
  logic [WIN_LOG2-1:0]  cnt_q, cnt_d;
  logic [FlatW-1:0]     acc_q, acc_d;
  logic [FlatW-1:0]     out_value_q, out_value_d;
  logic                 out_valid_q, out_valid_d;
  logic                 start_err_q, start_err_d;
  logic [FlatW-1:0]     sum_flat;

  // Per-lane accumulator plus this cycle's sample: +1, -1 or 0 (p=n cancels out).
  // The range [-N, +N] fits OUT_WIDTH bits, so no saturation is needed.
  always_comb begin
    sum_flat = acc_q;
    for (int i = 0; i < VEC_LEN; i++) begin
      if (in_p[i] && !in_n[i]) begin
        sum_flat[i*OUT_WIDTH +: OUT_WIDTH] = acc_q[i*OUT_WIDTH +: OUT_WIDTH] + OUT_WIDTH'(1);
      end else if (!in_p[i] && in_n[i]) begin
        sum_flat[i*OUT_WIDTH +: OUT_WIDTH] = acc_q[i*OUT_WIDTH +: OUT_WIDTH] - OUT_WIDTH'(1);
      end
    end
  end

  // Control FSM: a window runs, its result is held, then handed off.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_value_d = out_value_q;
    out_valid_d = out_valid_q;
    start_err_d = start_err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAccum;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      StAccum: begin
        acc_d = sum_flat;
        cnt_d = cnt_q + WIN_LOG2'(1);
        if (start) begin
          start_err_d = 1'b1;
        end
        // The last sample lands in the result register directly.
        if (cnt_q == '1) begin
          out_value_d = sum_flat;
          out_valid_d = 1'b1;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (start) begin
            // Back-to-back window with no idle cycle in between.
            state_d = StAccum;
            cnt_d   = '0;
            acc_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else if (start) begin
          start_err_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers. Reset clears everything, including any partial or held result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_value_q <= '0;
      out_valid_q <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_value_q <= out_value_d;
      out_valid_q <= out_valid_d;
      start_err_q <= start_err_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign start_err = start_err_q;

endmodule

// File: tb/tb_stoch_vec_decoder.sv
// Directed bench for stoch_vec_decoder with VEC_LEN=2, WIN_LOG2=4 (N=16, 6-bit lanes).
module tb_stoch_vec_decoder;

  localparam int unsigned VecLen  = 2;
  localparam int unsigned WinLog2 = 4;
  localparam int unsigned OutW    = WinLog2 + 2;

  logic                     clk;
  logic                     rst;
  logic                     start;
  logic [VecLen-1:0]        in_p;
  logic [VecLen-1:0]        in_n;
  logic                     busy;
  logic                     out_valid;
  logic                     out_ready;
  logic [VecLen*OutW-1:0]   out_value;
  logic                     start_err;

  int n_cmp;
  int n_bad;

  stoch_vec_decoder #(
    .VEC_LEN  (VecLen),
    .WIN_LOG2 (WinLog2)
  ) u_dut (
    .CLK       (clk),
    .RST       (rst),
    .start     (start),
    .in_p      (in_p),
    .in_n      (in_n),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .start_err (start_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    in_p      = '0;
    in_n      = '0;
    out_ready = 1'b0;

    // Reset state, and start held during reset must be ignored.
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_value", 32'(out_value), 32'd0);
    check_val("rst_err", 32'(start_err), 32'd0);
    start = 1'b1;
    tick();
    check_val("rst_start_ignored", 32'(busy), 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    tick();

    // Constant inputs: lane0 +1 every sample, lane1 -1 every sample.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("c_busy_after_start", 32'(busy), 32'd1);
    for (int j = 1; j <= 16; j++) begin
      in_p = 2'b01;
      in_n = 2'b10;
      if (j == 16) check_val("c_valid_before_last", 32'(out_valid), 32'd0);
      tick();
    end
    check_val("c_valid", 32'(out_valid), 32'd1);
    check_val("c_value", 32'(out_value), 32'h0C10);
    check_val("c_busy_hold", 32'(busy), 32'd1);

    // Backpressure: result stays put for 5 cycles.
    in_p = 2'b11;
    in_n = 2'b00;
    for (int j = 0; j < 5; j++) begin
      tick();
      check_val("bp_valid", 32'(out_valid), 32'd1);
      check_val("bp_value", 32'(out_value), 32'h0C10);
    end

    // Accept with start: back-to-back window running the 1010 pattern on lane0, p=n on lane1.
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check_val("b2b_busy", 32'(busy), 32'd1);
    check_val("b2b_valid_drop", 32'(out_valid), 32'd0);
    for (int j = 1; j <= 16; j++) begin
      in_p = {1'b1, 1'(j % 2)};
      in_n = 2'b10;
      if (j == 16) check_val("pat_value_held", 32'(out_value), 32'h0C10);
      tick();
    end
    check_val("pat_valid", 32'(out_valid), 32'd1);
    check_val("pat_value", 32'(out_value), 32'h0008);

    // Accept without start: back to idle.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("acc_valid", 32'(out_valid), 32'd0);
    check_val("acc_busy", 32'(busy), 32'd0);

    // Protocol violation: start pulse during sample 7 must not disturb the window.
    // lane0: 12 x +1 then 4 x -1 = +8; lane1: 3 x -1 = -3.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      in_p  = {1'b0, 1'(j <= 12)};
      in_n  = {1'(j <= 3), 1'(j > 12)};
      start = (j == 7);
      if (j == 7) check_val("pv_err_before", 32'(start_err), 32'd0);
      tick();
      if (j == 7) check_val("pv_err_set", 32'(start_err), 32'd1);
    end
    start = 1'b0;
    check_val("pv_valid", 32'(out_valid), 32'd1);
    check_val("pv_value", 32'(out_value), 32'h0F48);
    tick();
    check_val("pv_still_hold", 32'(out_valid), 32'd1);
    check_val("pv_value_stable", 32'(out_value), 32'h0F48);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("pv_idle", 32'(busy), 32'd0);
    check_val("pv_err_sticky", 32'(start_err), 32'd1);

    // Asynchronous reset between edges during sample 10.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      in_p = 2'b11;
      in_n = 2'b00;
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    check_val("ar_busy", 32'(busy), 32'd0);
    check_val("ar_valid", 32'(out_valid), 32'd0);
    check_val("ar_value", 32'(out_value), 32'd0);
    check_val("ar_err", 32'(start_err), 32'd0);
    #1;
    rst = 1'b0;
    tick();
    check_val("ar_idle_after", 32'(busy), 32'd0);

    // Fresh window after reset: lane0 -16, lane1 +5.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      in_p = {1'(j <= 5), 1'b0};
      in_n = 2'b01;
      tick();
    end
    check_val("ar_fresh_valid", 32'(out_valid), 32'd1);
    check_val("ar_fresh_value", 32'(out_value), 32'h0170);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
